hamming_secded_rx: RTL and testbench

- Receive-side counterpart to the Hamming encoder: SECDED decoder and corrector for one codeword per transfer.
- Takes a received pattern/parity pair, computes syndrome and overall parity, corrects single-bit errors and flags double-bit errors.
- Two-stage pipeline with valid/ready handshake on both sides, plus saturating error-statistics counters.
- Sits between the channel (error injector in the bench) and the pattern consumer/checker.

---
 rtl/hamming_secded_rx_pkg.sv | 53 +++++
 rtl/hamming_secded_rx_syndrome_calc.sv | 29 ++
 rtl/hamming_secded_rx.sv | 158 +++++++++++++++
 tb/tb_hamming_secded_rx.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_secded_rx_pkg.sv
// Shared SECDED code constants, types and position helpers.
// Used by the receive decoder and the matching encoder.
package hamming_secded_rx_pkg;

  localparam int DATA_W = 8;
  localparam int HAM_W  = 4;
  localparam int PAR_W  = HAM_W + 1;
  localparam int CODE_N = DATA_W + HAM_W;
  localparam int IDX_W  = $clog2(DATA_W);

  typedef logic [DATA_W-1:0] pattern_t;
  typedef logic [PAR_W-1:0]  parity_t;
  typedef logic [HAM_W-1:0]  syn_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_type_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } didx_t;

  // Codeword position of data bit idx (non-power-of-two slots, ascending).
  function automatic syn_t data_pos(input int idx);
    int   cnt;
    syn_t pos;
    cnt = 0;
    pos = '0;
    for (int p = 1; p <= CODE_N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = syn_t'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic didx_t pos_to_idx(input syn_t pos);
    didx_t r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_pos(i) == pos) begin
        r.vld = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_secded_rx_syndrome_calc.sv
// Combinational syndrome and overall parity check.
// Shared with the encoder model.
module hamming_syndrome_calc
  import hamming_secded_rx_pkg::*;
(
  input  pattern_t   i_pattern,
  input  parity_t    i_parity,
  output syn_t       o_syn,
  output logic       o_perr
);

  syn_t calc;
  syn_t pos;

  always_comb begin
    calc = '0;
    pos  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = data_pos(i);
      for (int k = 0; k < HAM_W; k++) begin
        if (pos[k]) calc[k] = calc[k] ^ i_pattern[i];
      end
    end
  end

  assign o_syn  = calc ^ i_parity[HAM_W-1:0];
  assign o_perr = ^{i_pattern, i_parity};

endmodule

// File: rtl/hamming_secded_rx.sv
// SECDED receive decoder: 2-stage valid/ready pipeline
// with saturating corrected/uncorrectable counters.
module hamming_secded_rx
  import hamming_secded_rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_pattern,
  input  logic [PAR_W-1:0]  i_parity,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_pattern,
  output logic [PAR_W-1:0]  o_syndrome,
  output logic [1:0]        o_err_type,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_cnt_corr,
  output logic [CNT_W-1:0]  o_cnt_uncorr
);

  logic       adv1, adv2, fire;
  syn_t       syn;
  logic       perr;

  logic       s1_valid_q, s1_valid_d;
  pattern_t   s1_pat_q, s1_pat_d;
  syn_t       s1_syn_q, s1_syn_d;
  logic       s1_perr_q, s1_perr_d;

  logic       o_valid_q, o_valid_d;
  pattern_t   o_pat_q, o_pat_d;
  parity_t    o_syn_q, o_syn_d;
  err_type_t  o_err_q, o_err_d;

  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_unc_q, cnt_unc_d;

  didx_t      didx;
  pattern_t   cls_pat;
  err_type_t  cls_err;
  logic       nz, big;

  hamming_syndrome_calc u_syn (
    .i_pattern (i_pattern),
    .i_parity  (i_parity),
    .o_syn     (syn),
    .o_perr    (perr)
  );

  assign adv2    = i_en && (!o_valid_q || i_ready);
  assign adv1    = i_en && (!s1_valid_q || adv2);
  assign fire    = o_valid_q && adv2;
  assign o_ready = adv1;

  // Classification cases are mutually exclusive by construction.
  always_comb begin
    didx    = pos_to_idx(s1_syn_q);
    nz      = (s1_syn_q != '0);
    big     = (s1_syn_q > syn_t'(CODE_N));
    cls_pat = s1_pat_q;
    cls_err = ERR_NONE;
    unique case (1'b1)
      (!s1_perr_q && !nz): cls_err = ERR_NONE;
      (!s1_perr_q && nz):  cls_err = ERR_UNCORR;
      (s1_perr_q && !nz):  cls_err = ERR_CORR;
      (s1_perr_q && didx.vld): begin
        cls_pat[didx.idx] = ~s1_pat_q[didx.idx];
        cls_err = ERR_CORR;
      end
      (s1_perr_q && big):  cls_err = ERR_UNCORR;
      (s1_perr_q && nz && !big && !didx.vld):
        cls_err = ERR_CORR;
      default: cls_err = ERR_NONE;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pat_d   = s1_pat_q;
    s1_syn_d   = s1_syn_q;
    s1_perr_d  = s1_perr_q;
    if (adv1) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_pat_d  = i_pattern;
        s1_syn_d  = syn;
        s1_perr_d = perr;
      end
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_pat_d   = o_pat_q;
    o_syn_d   = o_syn_q;
    o_err_d   = o_err_q;
    if (adv2) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_pat_d = cls_pat;
        o_syn_d = {s1_perr_q, s1_syn_q};
        o_err_d = cls_err;
      end
    end
  end

  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;
    if (i_clr_cnt) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (fire) begin
      if (o_err_q == ERR_CORR && cnt_corr_q != '1)
        cnt_corr_d = cnt_corr_q + 1'b1;
      if (o_err_q == ERR_UNCORR && cnt_unc_q != '1)
        cnt_unc_d = cnt_unc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pat_q   <= '0;
      s1_syn_q   <= '0;
      s1_perr_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_pat_q    <= '0;
      o_syn_q    <= '0;
      o_err_q    <= ERR_NONE;
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pat_q   <= s1_pat_d;
      s1_syn_q   <= s1_syn_d;
      s1_perr_q  <= s1_perr_d;
      o_valid_q  <= o_valid_d;
      o_pat_q    <= o_pat_d;
      o_syn_q    <= o_syn_d;
      o_err_q    <= o_err_d;
      cnt_corr_q <= cnt_corr_d;
      cnt_unc_q  <= cnt_unc_d;
    end
  end

  assign o_valid      = o_valid_q;
  assign o_pattern    = o_pat_q;
  assign o_syndrome   = o_syn_q;
  assign o_err_type   = o_err_q;
  assign o_cnt_corr   = cnt_corr_q;
  assign o_cnt_uncorr = cnt_unc_q;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Scoreboard bench for hamming_secded_rx (DATA_W=8, CNT_W=4).
// Independent codeword model; outputs sampled on negedge.
module tb_hamming_secded_rx;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b1;
  logic [7:0] i_pattern = '0;
  logic [4:0] i_parity = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] o_pattern;
  logic [4:0] o_syndrome;
  logic [1:0] o_err_type;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic       i_clr_cnt = 1'b0;
  logic [3:0] o_cnt_corr;
  logic [3:0] o_cnt_uncorr;

  hamming_secded_rx #(.CNT_W(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_pattern    (i_pattern),
    .i_parity     (i_parity),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_pattern    (o_pattern),
    .o_syndrome   (o_syndrome),
    .o_err_type   (o_err_type),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .i_clr_cnt    (i_clr_cnt),
    .o_cnt_corr   (o_cnt_corr),
    .o_cnt_uncorr (o_cnt_uncorr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] pat;
    logic [4:0] syn;
    logic [1:0] typ;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         out_cyc[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         chk_lat = 1'b0;
  bit         rnd_on = 1'b0;
  logic [3:0] mc_corr = '0;
  logic [3:0] mc_unc = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit is_p2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [4:0] enc(input logic [7:0] pat);
    int s;
    int d;
    s = 0;
    d = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_p2(pos)) begin
        if (pat[d]) s = s ^ pos;
        d++;
      end
    end
    return {^pat ^ ^s[3:0], s[3:0]};
  endfunction

  function automatic exp_t model(input logic [7:0] pat,
                                 input logic [4:0] par);
    logic [12:1] cw;
    int   s, d, k;
    logic p;
    exp_t e;
    d = 0;
    k = 0;
    s = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (is_p2(pos)) begin
        cw[pos] = par[k];
        k++;
      end else begin
        cw[pos] = pat[d];
        d++;
      end
      if (cw[pos]) s = s ^ pos;
    end
    p = ^cw ^ par[4];
    e.syn = {p, s[3:0]};
    e.typ = 2'b00;
    if (p) begin
      e.typ = (s > 12) ? 2'b10 : 2'b01;
      if (s != 0 && s <= 12) cw[s] = ~cw[s];
    end else if (s != 0) begin
      e.typ = 2'b10;
    end
    d = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (!is_p2(pos)) begin
        e.pat[d] = cw[pos];
        d++;
      end
    end
    e.cyc = 0;
    return e;
  endfunction

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (o_valid && i_ready && i_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pattern", o_pattern, e.pat);
          chk("syndrome", o_syndrome, e.syn);
          chk("err_type", o_err_type, e.typ);
          if (chk_lat) chk("latency", cyc - e.cyc, 2);
          out_cyc.push_back(cyc);
          if (!i_clr_cnt) begin
            if (e.typ == 2'b01 && mc_corr != 4'hF) mc_corr++;
            if (e.typ == 2'b10 && mc_unc != 4'hF) mc_unc++;
          end
        end
      end
      if (i_clr_cnt) begin
        mc_corr = '0;
        mc_unc  = '0;
      end
      if (i_valid && o_ready) begin
        e = model(i_pattern, i_parity);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] pat, input logic [4:0] par);
    int n;
    bit acc;
    i_valid   = 1'b1;
    i_pattern = pat;
    i_parity  = par;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 60) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_chk(input string tag, input logic [7:0] pat,
                          input logic [4:0] par, input logic [7:0] epat,
                          input logic [4:0] esyn, input logic [1:0] etyp);
    int n;
    send(pat, par);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 6);
    chk({tag, "_pat"}, o_pattern, epat);
    chk({tag, "_syn"}, o_syndrome, esyn);
    chk({tag, "_typ"}, o_err_type, etyp);
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ovalid();
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 10);
    chk("ovalid_wait", o_valid, 1);
  endtask

  initial begin
    logic [12:0] cw;
    logic [7:0]  d;
    int          a, b;

    #12;
    chk("rst_ovalid", o_valid, 0);
    chk("rst_pat", o_pattern, 0);
    chk("rst_syn", o_syndrome, 0);
    chk("rst_typ", o_err_type, 0);
    chk("rst_cnt_c", o_cnt_corr, 0);
    chk("rst_cnt_u", o_cnt_uncorr, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    chk_lat = 1'b1;
    send_chk("clean", 8'h00, 5'h00, 8'h00, 5'h00, 2'b00);
    chk("clean_cnt", o_cnt_corr, 0);
    send_chk("d0err", 8'h01, 5'h00, 8'h00, 5'h13, 2'b01);
    chk("d0err_cnt", o_cnt_corr, 1);
    send_chk("dbl", 8'h03, 5'h00, 8'h03, 5'h06, 2'b10);
    chk("dbl_cnt", o_cnt_uncorr, 1);
    send_chk("ovp", 8'h00, 5'h10, 8'h00, 5'h10, 2'b01);
    send_chk("hp2", 8'h00, 5'h04, 8'h00, 5'h14, 2'b01);
    send_chk("big", 8'h00, 5'h1F, 8'h00, 5'h1F, 2'b10);
    for (int i = 0; i < 8; i++) begin
      send(8'h5C ^ (8'h01 << i), enc(8'h5C));
    end
    drain();
    chk_lat = 1'b0;

    i_ready = 1'b0;
    out_cyc.delete();
    send(8'hA1, enc(8'hA1));
    send(8'hA2, enc(8'hA2));
    fork
      send(8'hA3, enc(8'hA3));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge i_clk);
          chk("bp_ready", o_ready, 0);
          chk("bp_valid", o_valid, 1);
          chk("bp_hold", o_pattern, 8'hA1);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", out_cyc.size(), 3);
    if (out_cyc.size() >= 3) begin
      chk("bp_gap1", out_cyc[1] - out_cyc[0], 1);
      chk("bp_gap2", out_cyc[2] - out_cyc[1], 1);
    end

    i_ready = 1'b0;
    send(8'h11, enc(8'h11));
    send(8'h22, enc(8'h22) ^ 5'h01);
    i_en = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("en_ready", o_ready, 0);
      chk("en_hold", o_pattern, 8'h11);
    end
    @(posedge i_clk);
    #1;
    i_en = 1'b1;
    drain();

    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          d = 8'($urandom);
          cw = {enc(d), d};
          a = $urandom_range(0, 12);
          b = $urandom_range(0, 12);
          case ($urandom_range(0, 2))
            0: ;
            1: cw[a] = ~cw[a];
            default: begin
              cw[a] = ~cw[a];
              if (b != a) cw[b] = ~cw[b];
            end
          endcase
          send(cw[7:0], cw[12:8]);
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge i_clk);
        #1;
        i_ready = 1'($urandom);
      end
    join
    i_ready = 1'b1;
    drain();
    chk("rnd_cnt_c", o_cnt_corr, mc_corr);
    chk("rnd_cnt_u", o_cnt_uncorr, mc_unc);

    i_clr_cnt = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_cnt = 1'b0;
    chk("clr_cnt_c", o_cnt_corr, 0);
    chk("clr_cnt_u", o_cnt_uncorr, 0);
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      send(d ^ (8'h01 << (i % 8)), enc(d));
    end
    drain();
    chk("sat_cnt", o_cnt_corr, 4'hF);
    chk("sat_model", o_cnt_corr, mc_corr);

    i_ready = 1'b0;
    send(8'h80, enc(8'h00));
    wait_ovalid();
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    i_clr_cnt = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_cnt = 1'b0;
    chk("clr_win", o_cnt_corr, 0);
    chk("clr_sb", sb.size(), 0);

    i_ready = 1'b0;
    send(8'hA5, enc(8'hA5));
    send(8'h5A, enc(8'h5A) ^ 5'h02);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", o_valid, 0);
    chk("mrst_cnt", o_cnt_corr, 0);
    sb.delete();
    mc_corr = '0;
    mc_unc  = '0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("no_stale", o_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
